team_06_wb_sram_responder: RTL

// - Wishbone classic subordinate; the responder end of the bus driven by our wishbone_manager.
// - Backs the readWrite audio delay buffer with a local word-addressed register array.
// - Lets the audio path run standalone (FPGA bring-up, sim) without the chip-level SRAM.
// - Supports byte-lane writes, configurable wait states and abort on CYC drop.

---
 rtl/team_06_wb_sram_responder_if.sv | 22 ++
 rtl/team_06_wb_sram_responder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/team_06_wb_sram_responder_if.sv
// Wishbone classic bus bundle between our wishbone_manager and the SRAM responder.
interface team_06_wb_sram_responder_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/team_06_wb_sram_responder.sv
// Wishbone classic responder backed by a local word array, with byte lanes, wait states and abort.
// Optional macro TEAM_06_WB_RESP_ERR_EN: out-of-range addresses get ERR instead of aliasing.
module team_06_wb_sram_responder #(
   parameter int unsigned DEPTH       = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   team_06_wb_sram_responder_if.slave    wb
);

`ifdef TEAM_06_WB_RESP_ERR_EN
   localparam bit LP_ERR_EN = 1'b1;
`else
   localparam bit LP_ERR_EN = 1'b0;
`endif

   localparam int unsigned AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] LP_SPAN      = 32'(4 * DEPTH);
   localparam logic [3:0]  LP_WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [AW-1:0] r_idx;
   logic [31:0] r_dat;
   logic [3:0]  r_sel;
   logic        r_we;
   logic        r_oor;
   logic        r_ack;
   logic        r_err;
   logic [31:0] r_rdata;
   logic [31:0] r_mem [DEPTH];

   logic [31:0]   w_off;
   logic [AW-1:0] w_idx;
   logic          w_req;
   logic          w_oor;
   logic          w_unused_lo;
   logic          w_fire;
   logic [AW-1:0] w_rsp_idx;
   logic          w_rsp_we;
   logic          w_rsp_oor;
   logic          w_mem_we;

   assign w_off       = wb.wb_adr_i - BASE_ADDR;
   assign w_idx       = w_off[AW+1:2];
   assign w_unused_lo = ^w_off[1:0];
   assign w_req       = wb.wb_cyc_i & wb.wb_stb_i;
   // Unsigned offset compare also catches addresses below BASE_ADDR (they wrap high).
   assign w_oor       = LP_ERR_EN && (w_off >= LP_SPAN);

   // With zero wait states the response is launched straight from IDLE using the live
   // request, since the latched copy only becomes visible one edge later.
   always_comb begin
      w_fire    = 1'b0;
      w_rsp_idx = r_idx;
      w_rsp_we  = r_we;
      w_rsp_oor = r_oor;
      if (r_state == S_IDLE) begin
         w_rsp_idx = w_idx;
         w_rsp_we  = wb.wb_we_i;
         w_rsp_oor = w_oor;
         w_fire    = w_req && (WAIT_CYCLES == 0);
      end else if (r_state == S_WAIT) begin
         w_fire    = w_req && (r_cnt == LP_WAIT_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_dat   <= '0;
         r_sel   <= '0;
         r_we    <= 1'b0;
         r_oor   <= 1'b0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_idx   <= w_idx;
                  r_dat   <= wb.wb_dat_i;
                  r_sel   <= wb.wb_sel_i;
                  r_we    <= wb.wb_we_i;
                  r_oor   <= w_oor;
                  r_cnt   <= '0;
                  r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (!w_req) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else if (r_cnt == LP_WAIT_LAST) begin
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase

         if (w_fire) begin
            if (w_rsp_oor) begin
               r_err <= 1'b1;
            end else begin
               r_ack <= 1'b1;
               if (!w_rsp_we) r_rdata <= r_mem[w_rsp_idx];
            end
         end
      end
   end

   assign w_mem_we = (r_state == S_RESP) && r_we && !r_oor;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (r_sel[b]) r_mem[r_idx][8*b +: 8] <= r_dat[8*b +: 8];
         end
      end
   end

   assign wb.wb_dat_o = r_rdata;
   assign wb.wb_ack_o = r_ack;
   assign wb.wb_err_o = r_err;

endmodule
